// File: rtl/ctrl_seq.sv
// Multi-cycle control sequencer: accepts one MIPS instruction per handshake and
// steps datapath strobes through IDLE/DECODE/EXEC/MEM/WB. Optional trap: CTRL_ILLEGAL_TRAP_EN.
module ctrl_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  output logic [25:0] Inst,
  output logic        RegDst,
  output logic        RegWrite,
  output logic        ALUSrc,
  output logic        MemWrite,
  output logic        MemRead,
  output logic        MemToReg,
  output logic [2:0]  ALUControl,
  output logic        retire,
  output logic        illegal
);

  typedef enum logic [2:0] {
    StIdle,
    StDecode,
    StExec,
    StMem,
    StWb
`ifdef CTRL_ILLEGAL_TRAP_EN
    , StHalt
`endif
  } state_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;

  state_e      state_q, state_d;
  logic [5:0]  op_q;
  logic [25:0] inst_q;

  logic       is_r, is_lw, is_sw, is_mem, funct_ok, r_ok, active;
  logic [2:0] alu_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      op_q    <= '0;
      inst_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && instr_valid) begin
        op_q   <= instr[31:26];
        inst_q <= instr[25:0];
      end
    end
  end

  // Decode works only on the latched word, so no path exists from instr to outputs.
  always_comb begin
    alu_r    = 3'b000;
    funct_ok = 1'b1;
    case (inst_q[5:0])
      6'h20:   alu_r = 3'b101;
      6'h22:   alu_r = 3'b110;
      6'h24:   alu_r = 3'b000;
      6'h25:   alu_r = 3'b001;
      6'h2A:   alu_r = 3'b111;
      default: funct_ok = 1'b0;
    endcase
  end

  assign is_r   = (op_q == OpRtype);
  assign is_lw  = (op_q == OpLw);
  assign is_sw  = (op_q == OpSw);
  assign is_mem = is_lw | is_sw;
  assign r_ok   = is_r & funct_ok;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (instr_valid) state_d = StDecode;
`ifdef CTRL_ILLEGAL_TRAP_EN
      StDecode: state_d = (r_ok | is_mem) ? StExec : StHalt;
      StHalt:   state_d = StHalt;
`else
      StDecode: state_d = StExec;
`endif
      // Illegal words fall through to WB as a NOP when not trapping.
      StExec:   state_d = is_mem ? StMem : StWb;
      StMem:    state_d = is_lw ? StWb : StIdle;
      StWb:     state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  assign active = (state_q inside {StDecode, StExec, StMem, StWb});

  always_comb begin
    instr_ready = (state_q == StIdle) & rst_n;
    Inst        = inst_q;
    RegDst      = active & r_ok;
    ALUSrc      = active & is_mem;
    MemToReg    = active & r_ok;
    ALUControl  = 3'b000;
    if (active) begin
      if (r_ok)        ALUControl = alu_r;
      else if (is_mem) ALUControl = 3'b101;
    end
    RegWrite = (state_q == StWb) & (r_ok | is_lw);
    MemWrite = (state_q == StMem) & is_sw;
    MemRead  = is_lw & ((state_q == StMem) | (state_q == StWb));
    retire   = (state_q == StWb) | ((state_q == StMem) & is_sw);
`ifdef CTRL_ILLEGAL_TRAP_EN
    illegal  = (state_q == StHalt);
`else
    illegal  = 1'b0;
`endif
  end

endmodule

// File: doc/ctrl_seq.md
# ctrl_seq

Multi-cycle control sequencer sitting directly upstream of `datapath`. It accepts one 32-bit MIPS instruction at a time from the fetch side over a valid/ready handshake and decodes the opcode and funct fields. It then drives the datapath control strobes and the 26-bit `Inst` field through a fixed state sequence, so register-file and data-memory writes happen on exactly one clock edge per instruction.

## Interface
Parameters:
- none

Ports:
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `instr_valid` in 1: fetch presents a valid instruction.
- `instr_ready` out 1: sequencer can accept an instruction.
- `instr` in 32: instruction word.
- `Inst` out 26: `instr[25:0]` latched at accept; drives datapath `Inst`.
- `RegDst` out 1: 1 = destination is rd, 0 = destination is rt.
- `RegWrite` out 1: register-file write strobe.
- `ALUSrc` out 1: 1 = sign-extended immediate, 0 = rt.
- `MemWrite` out 1: data-memory write strobe.
- `MemRead` out 1: data-memory read enable.
- `MemToReg` out 1: 1 = ALU result to register file, 0 = memory data.
- `ALUControl` out 3: ALU operation.
- `retire` out 1: one-cycle pulse in the final cycle of each instruction.
- `illegal` out 1: sticky unsupported-instruction flag (see Configuration).

## Operation
- Decode. `op = instr[31:26]`, `funct = instr[5:0]`.
  - R-type: op 000000.
  - `lw`: op 100011.
  - `sw`: op 101011.
- ALUControl for R-type:
  - add (funct 0x20) → 101
  - sub (0x22) → 110
  - and (0x24) → 000
  - or (0x25) → 001
  - slt (0x2A) → 111
- ALUControl for `lw`/`sw`: 101.
- Any other op, or an R-type with another funct, is illegal.
- States are IDLE, DECODE, EXEC, MEM, WB, HALT.
  - IDLE: `instr_ready`=1. When `instr_valid` is also 1 on a rising edge, latch `instr`, load `Inst`, and go to DECODE.
  - DECODE → EXEC.
  - EXEC: R-type → WB; `lw`/`sw` → MEM.
  - MEM: `lw` → WB; `sw` → IDLE.
  - WB → IDLE.
- Decoded static controls (`RegDst`, `ALUSrc`, `MemToReg`, `ALUControl`) are valid from DECODE through the last state and are 0 in IDLE.
  - R-type: RegDst=1, ALUSrc=0, MemToReg=1.
  - `lw`: RegDst=0, ALUSrc=1, MemToReg=0.
  - `sw`: ALUSrc=1; RegDst=0 and MemToReg=0.
- Strobes:
  - `RegWrite`=1 only in WB, one cycle.
  - `MemWrite`=1 only in the MEM state of `sw`, one cycle.
  - `MemRead`=1 in MEM and WB of `lw`.
- `retire`=1 in WB (R-type, `lw`) or in MEM (`sw`).
- `Inst` holds its value until the next accept; it is not cleared on return to IDLE.

## Timing
- Reset values: state IDLE, `Inst`=0, every control output 0, `retire`=0, `illegal`=0. `instr_ready`=1 once `rst_n` deasserts.
- Latency from the accept edge to the `retire` cycle:
  - R-type: 3 cycles (DECODE, EXEC, WB).
  - `lw`: 4 cycles.
  - `sw`: 3 cycles.
- Throughput: the next accept is possible the cycle after retire. There is no overlap and no pipelining.
- `instr_ready` is 0 in every state except IDLE. An `instr_valid` asserted outside IDLE is ignored; fetch must hold it.
- `rst_n` low at any point aborts the instruction in flight.
  - All strobes drop asynchronously.
  - No partial write is completed.
  - State returns to IDLE.
- All outputs are registered or decoded from registered state only; no combinational path runs from `instr` to any output.

## Configuration
- `CTRL_ILLEGAL_TRAP_EN` defined:
  - An illegal instruction goes DECODE → HALT.
  - `illegal` is set and held.
  - `instr_ready`=0, all strobes 0, `retire` never pulses.
  - Only `rst_n` exits HALT.
- `CTRL_ILLEGAL_TRAP_EN` undefined:
  - An illegal instruction executes as a NOP: DECODE → EXEC → WB with `RegWrite`=0 and `MemWrite`=0.
  - `retire` pulses in WB.
  - `illegal` is tied to 0 and the HALT state is not built.

## Test plan
- Add: `instr`=0x00430820 (add $1,$2,$3) with valid held → accept at edge 0. `Inst`=0x0430820, RegDst=1, ALUSrc=0, MemToReg=1, ALUControl=101 from DECODE. `RegWrite`=1 for exactly one cycle at edge 3 together with `retire`. `instr_ready` returns to 1 on the next cycle.
- Load: `instr`=0x8C410000 (lw $1,0($2)) → RegDst=0, ALUSrc=1, MemToReg=0. `MemRead`=1 in MEM and WB. `RegWrite`=1 and `retire`=1 only in WB, 4 cycles after accept. `MemWrite` stays 0 throughout.
- Store: `instr`=0xAC410000 (sw $1,0($2)) → `MemWrite`=1 for one cycle in MEM, coinciding with `retire`. `RegWrite` and `MemRead` stay 0. Back to IDLE 3 cycles after accept.
- Handshake: `instr_valid` held high with add, then sw queued back-to-back → accepts occur only on IDLE cycles, 4 cycles apart. No instruction is dropped or accepted twice.
- Illegal: `instr`=0xFC000000.
  - With the macro: HALT, `illegal`=1, `instr_ready`=0 until `rst_n` pulses low.
  - Without the macro: `retire` pulses 3 cycles after accept with no write strobe.
- Reset mid-op: assert `rst_n`=0 during the MEM state of `sw` → `MemWrite` drops immediately and all outputs are 0. After release, `instr_ready`=1 and a new add executes normally.
